// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing defaults and constants
// for the integer register file.
package reg_file_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational read mux
// with the hard-wired zero register forced to 0.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH,
    parameter int NR = NUM_REGS
) (
    input  logic [NR-1:0][DW-1:0] i_regs,
    input  logic [AW-1:0]         i_addr,
    output logic [DW-1:0]         o_data
);

    logic w_hit;

    // Indices beyond NR (when NR < 2**AW) also read as zero
    assign w_hit = (i_addr != AW'(ZERO_REG))
                && (32'(i_addr) < 32'(NR));

    always_comb begin
        o_data = '0;
        if (w_hit) begin
            o_data = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: two-read, one-write flop-based register
// file with R0 hard-wired to zero and no write bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] regSource1,
    input  logic [ADDR_WIDTH-1:0] regSource2,
    input  logic [ADDR_WIDTH-1:0] regDestination,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_regs <= '0;
        end else begin
            r_regs[ZERO_REG] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (writeEnable
                    && regDestination == ADDR_WIDTH'(i)) begin
                    r_regs[i] <= writeData;
                end
            end
        end
    end

    reg_file_read_port #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH),
        .NR (NUM_REGS)
    ) u_rd1 (
        .i_regs (r_regs),
        .i_addr (regSource1),
        .o_data (data1)
    );

    reg_file_read_port #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH),
        .NR (NUM_REGS)
    ) u_rd2 (
        .i_regs (r_regs),
        .i_addr (regSource2),
        .o_data (data2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table vectors plus hand
// sequences for bypass, reset and R0 corner cases.
`timescale 1ns/100ps
module tb_reg_file;

    logic        clock;
    logic        reset;
    logic [2:0]  regSource1;
    logic [2:0]  regSource2;
    logic [2:0]  regDestination;
    logic [15:0] writeData;
    logic        writeEnable;
    logic [15:0] data1;
    logic [15:0] data2;

    int pass_cnt = 0;
    int total_cnt = 0;

    reg_file dut (
        .clock          (clock),
        .reset          (reset),
        .regSource1     (regSource1),
        .regSource2     (regSource2),
        .regDestination (regDestination),
        .writeData      (writeData),
        .writeEnable    (writeEnable),
        .data1          (data1),
        .data2          (data2)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    typedef struct {
        logic        we;
        logic [2:0]  dest;
        logic [15:0] wd;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Sweep every index on both ports against an expected zero
    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            regSource1 = 3'(i);
            regSource2 = 3'(7 - i);
            #1;
            check($sformatf("%s_d1_r%0d", name, i), data1, 16'h0);
            check($sformatf("%s_d2_r%0d", name, 7 - i), data2, 16'h0);
        end
    endtask

    initial begin
        // we dest wd s1 s2 e1 e2 (e = value before the edge)
        vecs[0]  = '{1'b1, 3'd2, 16'h23FE, 3'd2, 3'd1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd1, 16'h23FE, 16'h0000};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'h0000, 16'h23FE};
        vecs[3]  = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd2, 16'h0000, 16'h23FE};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd6, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b1, 3'd6, 16'h1234, 3'd7, 3'd6, 16'hA5A5, 16'h0000};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 16'h1234, 16'hA5A5};
        vecs[8]  = '{1'b1, 3'd7, 16'h0F0F, 3'd7, 3'd7, 16'hA5A5, 16'hA5A5};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd6, 16'h0F0F, 16'h1234};
        vecs[10] = '{1'b0, 3'd5, 16'hBEEF, 3'd5, 3'd7, 16'h0000, 16'h0F0F};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd1, 16'h0000, 16'h0000};

        reset          = 1'b0;
        regSource1     = '0;
        regSource2     = '0;
        regDestination = 3'd1;
        writeData      = 16'hDEAD;
        writeEnable    = 1'b1;

        // Reset held across an edge with a write pending
        @(negedge clock);
        check_all_zero("rst_hold");
        @(negedge clock);
        writeEnable = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        check_all_zero("post_rst");

        foreach (vecs[k]) begin
            @(negedge clock);
            writeEnable    = vecs[k].we;
            regDestination = vecs[k].dest;
            writeData      = vecs[k].wd;
            regSource1     = vecs[k].s1;
            regSource2     = vecs[k].s2;
            #1;
            check($sformatf("vec%0d_d1", k), data1, vecs[k].e1);
            check($sformatf("vec%0d_d2", k), data2, vecs[k].e2);
        end

        // Same-cycle read of the register being written
        @(negedge clock);
        writeEnable    = 1'b1;
        regDestination = 3'd4;
        writeData      = 16'h6781;
        regSource1     = 3'd4;
        regSource2     = 3'd3;
        #1;
        check("nobypass_pre", data1, 16'h0000);
        @(posedge clock);
        #1;
        check("nobypass_post", data1, 16'h6781);
        check("r3_untouched", data2, 16'h0000);

        @(negedge clock);
        writeEnable = 1'b0;
        regSource1  = 3'd2;
        regSource2  = 3'd4;
        #1;
        check("dual_d1", data1, 16'h23FE);
        check("dual_d2", data2, 16'h6781);
        regSource1 = 3'd4;
        #1;
        check("same_d1", data1, 16'h6781);
        check("same_d2", data2, 16'h6781);

        // Async reset mid-cycle with a write held through it
        @(negedge clock);
        writeEnable    = 1'b1;
        regDestination = 3'd3;
        writeData      = 16'h1111;
        #1;
        reset = 1'b0;
        check_all_zero("async_rst");
        @(posedge clock);
        #1;
        regSource1 = 3'd3;
        regSource2 = 3'd4;
        #1;
        check("rst_we_ignored", data1, 16'h0000);
        check("rst_r4_clear", data2, 16'h0000);

        // Release between edges; write on the next edge lands
        @(negedge clock);
        reset     = 1'b1;
        writeData = 16'h5555;
        #1;
        check("release_pre", data1, 16'h0000);
        @(posedge clock);
        #1;
        check("release_write", data1, 16'h5555);
        check("release_r4", data2, 16'h0000);
        writeEnable = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
